da_bit_serializer: RTL
======================

// Module: da_bit_serializer
// PURPOSE
//  Parallel-to-bit-serial front end for the distributed-arithmetic FIR filters (da_rom_fir_filter /
//  symm_da_rom_fir_filter). It accepts NB_DATA-bit samples over a valid/ready handshake and buffers
//  them in a small FIFO. Each sample is emitted LSB-first, one bit per clock, on o_data/o_enable,
//  which drive the filter's i_data/i_enable directly. It flags stream gaps (underrun) that would
//  corrupt DA accumulation.
// PARAMETERS
//  NB_DATA     8  sample width; bits emitted per word (>=2)
//  FIFO_DEPTH  4  input buffer depth in words; power of 2, >=2
//  NB_LEVEL    3  width of o_level; must equal clog2(FIFO_DEPTH+1)
// PORTS
//  clock              in   1         system clock; all logic on rising edge
//  i_reset            in   1         synchronous reset, active-high
//  i_sample           in   NB_DATA   parallel sample, two's complement
//  i_valid            in   1         i_sample valid
//  o_ready            out  1         block can accept a word this cycle
//  i_clear_underrun   in   1         clears sticky o_underrun
//  o_data             out  1         serial bit to filter i_data
//  o_enable           out  1         o_data valid; to filter i_enable
//  o_sof              out  1         high on bit 0 (LSB) of each word
//  o_underrun         out  1         sticky: stream broke after having started
//  o_level            out  NB_LEVEL  current FIFO occupancy (0..FIFO_DEPTH)
// BEHAVIOUR
//  Reset: i_reset high at an edge clears FIFO pointers, shifter, bit counter and the started flag.
//   State <= IDLE; o_data, o_enable, o_sof, o_underrun <= 0; o_level = 0.
//   o_ready is forced 0 while i_reset is high. Reset mid-word aborts the word; no further bits are
//   emitted from it.
//  Handshake: o_ready = !i_reset && (level < FIFO_DEPTH), combinational. A word is written when
//   i_valid && o_ready at a rising edge. i_sample may change freely when i_valid is low.
//  FSM IDLE:
//   - FIFO non-empty -> pop head, load shifter, go SHIFT.
//   - Same edge: o_enable=1, o_sof=1, o_data=bit0, cnt=0.
//  FSM SHIFT: each edge, cnt++, shift right, o_data = next bit, o_sof=0.
//   At cnt==NB_DATA-1 (last bit shown) the next edge does one of:
//   - FIFO non-empty: pop and load the next word back-to-back (o_sof=1, no gap cycle).
//   - FIFO empty: go IDLE, o_enable=0, o_data=0; if the started flag is set, set o_underrun.
//  Latency: word accepted at edge k into an empty, IDLE block -> bit0 on outputs after edge k+1.
//   Bit i appears after edge k+1+i. Write and read at the same edge are both performed; the level
//   is unchanged.
//  Started flag: set on the first load after reset. An underrun is only flagged after streaming
//   has begun; the initial empty state never flags.
//  o_underrun: sticky until i_clear_underrun=1 at an edge. If clear and a new underrun coincide,
//   set wins.
//  o_level: registered occupancy; updates on the edge of the push/pop.
//  Full FIFO: o_ready=0 and writes are ignored. A pop that frees a slot raises o_ready the next
//   cycle, never in the same cycle.
//  FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer MSB.
// TESTING
//  1. Push 8'hA5 once -> o_data 1,0,1,0,0,1,0,1 over 8 cycles starting edge k+1; o_enable high
//     exactly 8 cycles; o_sof only on first; o_underrun=1 after the following edge.
//  2. Push 8'h01,8'h80,8'hFF back-to-back -> 24 contiguous o_enable cycles; o_sof at cycles
//     0,8,16; bit pattern matches LSB-first; underrun only after cycle 24.
//  3. Hold i_valid=1 with 6 words while the shifter is busy -> o_level reaches 4, o_ready=0;
//     words 5-6 accepted only after pops; output order preserved; no word lost or duplicated.
//  4. Reset asserted at bit 3 of word 8'h3C with 2 words queued -> next cycle o_enable=0,
//     o_level=0, o_ready=0; after release, no stale bits and no underrun flagged.
//  5. Set underrun, then pulse i_clear_underrun at the same edge another underrun occurs ->
//     o_underrun stays 1; a clear on a quiet edge -> 0.
//  6. End-to-end: drive da_rom_fir_filter from this block with the noisy-sine vector file ->
//     o_data of filter matches the bit-driven bench run sample for sample.

Source files
------------

// File: rtl/da_bit_serializer.sv
// Parallel-to-serial front end for the DA FIR filters: buffers samples in a small FIFO and
// emits each one LSB-first, one bit per clock, flagging stream gaps once streaming has begun.
module da_bit_serializer #(
    parameter int NB_DATA    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_LEVEL   = 3
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_DATA-1:0]  i_sample,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_clear_underrun,
    output logic                o_data,
    output logic                o_enable,
    output logic                o_sof,
    output logic                o_underrun,
    output logic [NB_LEVEL-1:0] o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NB_DATA);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [NB_DATA-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic [NB_LEVEL-1:0] level;
    logic [NB_DATA-1:0]  shreg;
    logic [NB_DATA-1:0]  head;
    logic [CW-1:0]       cnt;
    logic                started;
    logic                empty, push, pop, shift, go_idle, underrun_set;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty        = (wr_ptr == rd_ptr);
    assign o_ready      = !i_reset && (level < NB_LEVEL'(FIFO_DEPTH));
    assign push         = i_valid && o_ready;
    assign head         = mem[rd_ptr[AW-1:0]];
    assign o_level      = level;
    assign underrun_set = go_idle && started;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        shift   = 1'b0;
        go_idle = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(NB_DATA - 1)) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: the sample storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= i_sample;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            shreg      <= '0;
            cnt        <= '0;
            started    <= 1'b0;
            o_data     <= 1'b0;
            o_enable   <= 1'b0;
            o_sof      <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   level <= level + NB_LEVEL'(1);
                2'b01:   level <= level - NB_LEVEL'(1);
                default: level <= level;
            endcase

            if (pop) begin
                shreg    <= head >> 1;
                o_data   <= head[0];
                o_enable <= 1'b1;
                o_sof    <= 1'b1;
                cnt      <= '0;
                started  <= 1'b1;
            end else if (shift) begin
                shreg  <= shreg >> 1;
                o_data <= shreg[0];
                o_sof  <= 1'b0;
                cnt    <= cnt + CW'(1);
            end else if (go_idle) begin
                o_data   <= 1'b0;
                o_enable <= 1'b0;
                o_sof    <= 1'b0;
            end

            // A new underrun takes priority over a coincident clear.
            if (underrun_set)          o_underrun <= 1'b1;
            else if (i_clear_underrun) o_underrun <= 1'b0;
        end
    end

endmodule
